// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: load types, FSM states and
// architectural register numbers.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_stage_load_align.sv
// Big-endian sub-word extraction and alignment check for MIPS loads.
// Purely combinational.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte 0 is the most significant byte of the word.
  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[31:24];
      2'd1:    byte_sel = rdata_i[23:16];
      2'd2:    byte_sel = rdata_i[15:8];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  // Unlisted encodings fall through to the LW behaviour.
  always_comb begin
    data_o       = rdata_i;
    misaligned_o = (addr_i != 2'd0);
    case (load_type_e'(load_type_i))
      LT_LH: begin
        data_o       = {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_i[0];
      end
      LT_LHU: begin
        data_o       = {16'h0000, half_sel};
        misaligned_o = addr_i[0];
      end
      LT_LB: begin
        data_o       = {{24{byte_sel[7]}}, byte_sel};
        misaligned_o = 1'b0;
      end
      LT_LBU: begin
        data_o       = {24'h000000, byte_sel};
        misaligned_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: holds one result, waits for load data, drives the
// register-file write port and an identical bypass path for decode.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_write,
  input  logic [4:0]  in_wr,
  input  logic        in_mem_to_reg,
  input  logic [2:0]  in_load_type,
  input  logic        in_link,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus8,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        write,
  output logic [4:0]  WR,
  output logic [31:0] WD,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data,
  output logic        addr_error,
  output logic        mem_timeout
);

  localparam logic [31:0] TMO_LAST = MEM_TIMEOUT - 1;

  state_e      state_q, state_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  wr_q, wr_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [2:0]  load_type_q, load_type_d;
  logic        link_q, link_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] pc_plus8_q, pc_plus8_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  logic        accept;
  logic [31:0] load_data;
  logic        align_mis;
  logic        is_load;
  logic        bad_load;
  logic        in_wb;

  assign in_ready = (state_q != ST_WAIT);
  assign accept   = in_valid && in_ready;

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    reg_write_d  = reg_write_q;
    wr_d         = wr_q;
    mem_to_reg_d = mem_to_reg_q;
    load_type_d  = load_type_q;
    link_d       = link_q;
    alu_result_d = alu_result_q;
    pc_plus8_d   = pc_plus8_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    tmo_d        = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = ST_WB;
        end else if (MEM_TIMEOUT != 0 && cnt_q == TMO_LAST) begin
          state_d = ST_EMPTY;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        if (accept) begin
          reg_write_d  = in_reg_write;
          wr_d         = in_wr;
          mem_to_reg_d = in_mem_to_reg;
          load_type_d  = in_load_type;
          link_d       = in_link;
          alu_result_d = in_alu_result;
          pc_plus8_d   = in_pc_plus8;
          if (in_mem_to_reg && !in_link) begin
            state_d = ST_WAIT;
            cnt_d   = 32'd0;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          state_d = ST_EMPTY;
        end
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge values; reset is synchronous and beats any in-flight load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      reg_write_q  <= 1'b0;
      wr_q         <= REG_ZERO;
      mem_to_reg_q <= 1'b0;
      load_type_q  <= 3'd0;
      link_q       <= 1'b0;
      alu_result_q <= 32'd0;
      pc_plus8_q   <= 32'd0;
      rdata_q      <= 32'd0;
      cnt_q        <= 32'd0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_write_q  <= reg_write_d;
      wr_q         <= wr_d;
      mem_to_reg_q <= mem_to_reg_d;
      load_type_q  <= load_type_d;
      link_q       <= link_d;
      alu_result_q <= alu_result_d;
      pc_plus8_q   <= pc_plus8_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  wb_stage_load_align u_align (
    .rdata_i      (rdata_q),
    .addr_i       (alu_result_q[1:0]),
    .load_type_i  (load_type_q),
    .data_o       (load_data),
    .misaligned_o (align_mis)
  );

  // Alignment only matters for a real load; a link result ignores memory.
  assign is_load  = mem_to_reg_q && !link_q;
  assign bad_load = is_load && align_mis;
  assign in_wb    = (state_q == ST_WB);

  assign write       = in_wb && reg_write_q && (wr_q != REG_ZERO) && !bad_load;
  assign WR          = write ? wr_q : REG_ZERO;
  assign WD          = !write      ? 32'd0 :
                       link_q       ? pc_plus8_q :
                       mem_to_reg_q ? load_data : alu_result_q;
  assign addr_error  = in_wb && bad_load;
  assign mem_timeout = tmo_q;

  assign fwd_valid = write;
  assign fwd_reg   = WR;
  assign fwd_data  = WD;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table of instructions with expected
// writeback events fed through a scoreboard, plus reset and timeout sequences.
module tb_wb_stage;
  import wb_stage_pkg::*;

  typedef struct packed {
    logic        write;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        aerr;
    logic        tmo;
  } ev_t;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic        m2r;
    logic [2:0]  lt;
    logic        link;
    logic [31:0] alu;
    logic [31:0] pc8;
    logic [31:0] rdata;
    int          waitc;
    logic        ew;
    logic [31:0] ewd;
    logic        eae;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_wr;
  logic        in_mem_to_reg;
  logic [2:0]  in_load_type;
  logic        in_link;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus8;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        write;
  logic [4:0]  WR;
  logic [31:0] WD;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        addr_error;
  logic        mem_timeout;

  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  ev_t  exp_q[$];
  ev_t  mon_e;
  vec_t vecs[$];

  wb_stage #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_wr         (in_wr),
    .in_mem_to_reg (in_mem_to_reg),
    .in_load_type  (in_load_type),
    .in_link       (in_link),
    .in_alu_result (in_alu_result),
    .in_pc_plus8   (in_pc_plus8),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .write         (write),
    .WR            (WR),
    .WD            (WD),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data),
    .addr_error    (addr_error),
    .mem_timeout   (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic rw, logic [4:0] wr, logic m2r, logic [2:0] lt,
                              logic link, logic [31:0] alu, logic [31:0] pc8,
                              logic [31:0] rdata, int waitc, logic ew,
                              logic [31:0] ewd, logic eae);
    vec_t v;
    v.rw = rw; v.wr = wr; v.m2r = m2r; v.lt = lt; v.link = link;
    v.alu = alu; v.pc8 = pc8; v.rdata = rdata; v.waitc = waitc;
    v.ew = ew; v.ewd = ewd; v.eae = eae;
    return v;
  endfunction

  // Every write/addr_error/mem_timeout cycle must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (mon_en && (write === 1'b1 || addr_error === 1'b1 || mem_timeout === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {write, addr_error, mem_timeout}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_event", {write, WR, WD, addr_error, mem_timeout}, mon_e);
        check("fwd_path", {fwd_valid, fwd_reg, fwd_data}, {mon_e.write, mon_e.wr, mon_e.wd});
      end
    end
  end

  task automatic drive(input vec_t v);
    in_valid      = 1'b1;
    in_reg_write  = v.rw;
    in_wr         = v.wr;
    in_mem_to_reg = v.m2r;
    in_load_type  = v.lt;
    in_link       = v.link;
    in_alu_result = v.alu;
    in_pc_plus8   = v.pc8;
  endtask

  // Called at a negedge; returns at the negedge after the instruction's WB
  // cycle has been entered, leaving in_valid as the next call needs it.
  task automatic apply(input vec_t v);
    ev_t e;
    check("in_ready_accept", in_ready, 1);
    drive(v);
    if (v.ew || v.eae) begin
      e.write = v.ew;
      e.wr    = v.ew ? v.wr : 5'd0;
      e.wd    = v.ew ? v.ewd : 32'd0;
      e.aerr  = v.eae;
      e.tmo   = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (v.m2r && !v.link) begin
      in_valid = 1'b0;
      for (int k = 0; k < v.waitc; k++) begin
        check("in_ready_wait", in_ready, 0);
        @(negedge clk);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      check("in_ready_rvalid", in_ready, 0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    ev_t  e;
    //            rw wr  m2r lt      link alu           pc8           rdata         wt ew ewd           eae
    vecs.push_back(mk(1, 8,  0, LT_LW,  0, 32'h11,       32'h0,        32'h0,        0, 1, 32'h11,       0));
    vecs.push_back(mk(1, 9,  0, LT_LW,  0, 32'h22,       32'h0,        32'h0,        0, 1, 32'h22,       0));
    vecs.push_back(mk(1, 0,  0, LT_LW,  0, 32'h55,       32'h0,        32'h0,        0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 5,  0, LT_LW,  0, 32'h66,       32'h0,        32'h0,        0, 0, 32'h0,        0));
    vecs.push_back(mk(1, REG_RA, 0, LT_LW, 1, 32'hDEAD,  32'h0040_0010, 32'h0,       0, 1, 32'h0040_0010, 0));
    vecs.push_back(mk(1, 10, 0, LT_LW,  0, 32'h77,       32'h0,        32'h0,        0, 1, 32'h77,       0));
    vecs.push_back(mk(1, 4,  1, LT_LB,  0, 32'h1003,     32'h0,        32'h1234_5680, 3, 1, 32'hFFFF_FF80, 0));
    vecs.push_back(mk(1, 4,  1, LT_LBU, 0, 32'h1003,     32'h0,        32'h1234_5680, 3, 1, 32'h0000_0080, 0));
    vecs.push_back(mk(1, 5,  1, LT_LB,  0, 32'h2001,     32'h0,        32'hA1B2_C3D4, 0, 1, 32'hFFFF_FFB2, 0));
    vecs.push_back(mk(1, 6,  1, LT_LBU, 0, 32'h2002,     32'h0,        32'hA1B2_C3D4, 1, 1, 32'h0000_00C3, 0));
    vecs.push_back(mk(1, 7,  1, LT_LH,  0, 32'h2000,     32'h0,        32'h8001_7FFE, 0, 1, 32'hFFFF_8001, 0));
    vecs.push_back(mk(1, 7,  1, LT_LH,  0, 32'h2002,     32'h0,        32'h8001_7FFE, 2, 1, 32'h0000_7FFE, 0));
    vecs.push_back(mk(1, 11, 1, LT_LHU, 0, 32'h2002,     32'h0,        32'h8001_F00F, 0, 1, 32'h0000_F00F, 0));
    vecs.push_back(mk(1, 12, 1, LT_LW,  0, 32'h2004,     32'h0,        32'hCAFE_BABE, 2, 1, 32'hCAFE_BABE, 0));
    vecs.push_back(mk(1, 3,  0, LT_LW,  0, 32'h33,       32'h0,        32'h0,        0, 1, 32'h33,       0));
    vecs.push_back(mk(1, 13, 1, LT_LW,  0, 32'h1002,     32'h0,        32'h1111_2222, 1, 0, 32'h0,        1));
    vecs.push_back(mk(1, 14, 1, LT_LH,  0, 32'h1001,     32'h0,        32'h1111_2222, 0, 0, 32'h0,        1));
    vecs.push_back(mk(1, 0,  1, LT_LB,  0, 32'h3000,     32'h0,        32'h7F00_0000, 1, 0, 32'h0,        0));
    vecs.push_back(mk(1, 15, 1, 3'b111, 0, 32'h3000,     32'h0,        32'h0102_0304, 0, 1, 32'h0102_0304, 0));
    vecs.push_back(mk(1, REG_RA, 1, LT_LW, 1, 32'h3001,  32'h0000_1234, 32'h0,       0, 1, 32'h0000_1234, 0));
    vecs.push_back(mk(1, 16, 0, LT_LW,  0, 32'h44,       32'h0,        32'h0,        0, 1, 32'h44,       0));

    rst_n = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_wr = 5'd0;
    in_mem_to_reg = 1'b0; in_load_type = 3'd0; in_link = 1'b0;
    in_alu_result = 32'd0; in_pc_plus8 = 32'd0; mem_rdata = 32'd0; mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_outputs", {write, WR, WD, addr_error, mem_timeout}, 64'd0);
    check("reset_fwd", {fwd_valid, fwd_reg, fwd_data}, 64'd0);
    check("reset_in_ready", in_ready, 1);
    mon_en = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_write", write, 0);

    // Reset while a load is waiting: the late rvalid must be ignored.
    v = mk(1, 4, 1, LT_LW, 0, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    drive(v);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_wait_busy", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    check("rst_wait_outputs", {write, WR, WD, addr_error, mem_timeout}, 64'd0);
    check("rst_wait_ready", in_ready, 1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst_late_rvalid", {write, WR, WD}, 64'd0);
    check("rst_late_ready", in_ready, 1);
    @(negedge clk);
    check("rst_late_rvalid2", {write, WR, WD}, 64'd0);

    // Load with no memory response aborts after four WAIT cycles.
    v = mk(1, 20, 1, LT_LW, 0, 32'h200, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    drive(v);
    e = '{write: 1'b0, wr: 5'd0, wd: 32'd0, aerr: 1'b0, tmo: 1'b1};
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("tmo_wait_busy", {in_ready, mem_timeout}, 0);
      @(negedge clk);
    end
    check("tmo_pulse", {mem_timeout, write, in_ready}, 3'b101);
    @(negedge clk);
    check("tmo_pulse_end", {mem_timeout, write, in_ready}, 3'b001);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
